// File: rtl/bitwise_pipe.sv
// -----------------------------------------------------------------------------
// bitwise_pipe
//   Per-bit logic unit (AND/OR/XOR/NAND/NOR/XNOR/NOT a/pass a) feeding a
//   2-entry result FIFO with valid/ready handshakes on both sides.
//   The FIFO head is held in an output register, so y, out_valid and in_ready
//   are all registered. There is no combinational path from a/b/op to y, and
//   none from out_ready to in_ready.
//
//   Parameters
//     WIDTH      operand/result width, 1..64
//
//   Ports
//     clk        clock, rising edge
//     rst        synchronous active-high reset
//     in_valid   request present on a, b, op
//     in_ready   request can be accepted this cycle (registered, count < 2)
//     a, b       operands
//     op         000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR,
//                110 NOT a, 111 pass a
//     out_valid  result present on y
//     out_ready  consumer takes the result this cycle
//     y          head result (all zeros when the FIFO is empty)
//     zero, neg  result flags. These ports exist only when the macro
//                LOGIC_FLAGS_EN is defined. zero=1, neg=0 when the FIFO
//                is empty.
// -----------------------------------------------------------------------------
module bitwise_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef LOGIC_FLAGS_EN
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             neg
`else
   output logic [WIDTH-1:0] y
`endif
);

   function automatic logic [WIDTH-1:0] logic_op(input logic [2:0]       f,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] z);
      logic [WIDTH-1:0] r;
      case (f)
         3'b000:  r = x & z;
         3'b001:  r = x | z;
         3'b010:  r = x ^ z;
         3'b011:  r = ~(x & z);
         3'b100:  r = ~(x | z);
         3'b101:  r = ~(x ^ z);
         3'b110:  r = ~x;
         default: r = x;
      endcase
      return r;
   endfunction

   // ---- stage p0: operation evaluated on the incoming request ----
   logic [WIDTH-1:0] res_p0;
   logic             accept;
   logic             pop;

   // ---- stage p1: FIFO storage, pointers and registered head ----
   logic [WIDTH-1:0] mem_p1 [2];
   logic             wr_ptr_p1;
   logic             rd_ptr_p1;
   logic [1:0]       cnt_p1;
   logic             rdy_p1;
   logic             vld_p1;
   logic [WIDTH-1:0] y_p1;

   logic [1:0]       cnt_nx;
   logic             rd_nx;
   logic             head_is_new;
   logic [WIDTH-1:0] head_nx;

`ifdef LOGIC_FLAGS_EN
   logic             zmem_p1 [2];
   logic             nmem_p1 [2];
   logic             zero_p1;
   logic             neg_p1;
   logic             zhead_nx;
   logic             nhead_nx;
`endif

   always_comb begin
      res_p0 = logic_op(op, a, b);
      accept = in_valid && rdy_p1;
      pop    = vld_p1 && out_ready;
      cnt_nx = cnt_p1 + {1'b0, accept} - {1'b0, pop};
      rd_nx  = rd_ptr_p1 ^ pop;
      // The entry becoming head may be the one written on this very edge,
      // so it is bypassed from the operation result instead of read from mem.
      head_is_new = accept && (wr_ptr_p1 == rd_nx);
      head_nx     = head_is_new ? res_p0 : mem_p1[rd_nx];
`ifdef LOGIC_FLAGS_EN
      zhead_nx = head_is_new ? (res_p0 == '0) : zmem_p1[rd_nx];
      nhead_nx = head_is_new ? res_p0[WIDTH-1] : nmem_p1[rd_nx];
`endif
   end

   // Result storage is data only: it is never cleared. Reset still blocks
   // the write so that an accept coinciding with reset leaves no trace.
   always_ff @(posedge clk) begin
      if (accept && !rst) begin
         mem_p1[wr_ptr_p1] <= res_p0;
`ifdef LOGIC_FLAGS_EN
         zmem_p1[wr_ptr_p1] <= (res_p0 == '0);
         nmem_p1[wr_ptr_p1] <= res_p0[WIDTH-1];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_p1    <= 2'd0;
         wr_ptr_p1 <= 1'b0;
         rd_ptr_p1 <= 1'b0;
         rdy_p1    <= 1'b1;
         vld_p1    <= 1'b0;
         y_p1      <= '0;
`ifdef LOGIC_FLAGS_EN
         zero_p1   <= 1'b1;
         neg_p1    <= 1'b0;
`endif
      end else begin
         cnt_p1    <= cnt_nx;
         wr_ptr_p1 <= wr_ptr_p1 ^ accept;
         rd_ptr_p1 <= rd_nx;
         rdy_p1    <= (cnt_nx != 2'd2);
         vld_p1    <= (cnt_nx != 2'd0);
         y_p1      <= (cnt_nx != 2'd0) ? head_nx : '0;
`ifdef LOGIC_FLAGS_EN
         zero_p1   <= (cnt_nx != 2'd0) ? zhead_nx : 1'b1;
         neg_p1    <= (cnt_nx != 2'd0) ? nhead_nx : 1'b0;
`endif
      end
   end

   assign in_ready  = rdy_p1;
   assign out_valid = vld_p1;
   assign y         = y_p1;
`ifdef LOGIC_FLAGS_EN
   assign zero      = zero_p1;
   assign neg       = neg_p1;
`endif

endmodule

// File: tb/tb_bitwise_pipe.sv
// -----------------------------------------------------------------------------
// tb_bitwise_pipe
//   Self-checking bench for bitwise_pipe (WIDTH=16). It keeps a queue-based
//   reference of the FIFO contents and compares the outputs after every edge.
//   Fixed vectors and hand-written corner-case sequences are included.
//   Define LOGIC_FLAGS_EN to also cover the zero/neg ports.
// -----------------------------------------------------------------------------
module tb_bitwise_pipe;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [2:0]   op = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] y;
`ifdef LOGIC_FLAGS_EN
   logic         zero;
   logic         neg;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   logic [W-1:0] mq [$];

   always #5 clk = ~clk;

   bitwise_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef LOGIC_FLAGS_EN
      .y         (y),
      .zero      (zero),
      .neg       (neg)
`else
      .y         (y)
`endif
   );

   function automatic logic [W-1:0] ref_op(input logic [2:0] f,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] z);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) begin
         case (f)
            3'd0: r[i] = x[i] && z[i];
            3'd1: r[i] = x[i] || z[i];
            3'd2: r[i] = x[i] != z[i];
            3'd3: r[i] = !(x[i] && z[i]);
            3'd4: r[i] = !(x[i] || z[i]);
            3'd5: r[i] = x[i] == z[i];
            3'd6: r[i] = !x[i];
            default: r[i] = x[i];
         endcase
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the reference queue, compare outputs.
   task automatic cycle(input logic r, input logic iv, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic [2:0] iop, input logic ordy);
      bit           acc;
      bit           pp;
      logic [W-1:0] res;
      logic [W-1:0] exp_y;
      rst = r; in_valid = iv; a = ia; b = ib; op = iop; out_ready = ordy;
      acc = iv && (mq.size() < 2);
      pp  = (mq.size() != 0) && ordy;
      res = ref_op(iop, ia, ib);
      @(posedge clk);
      if (r) mq.delete();
      else begin
         if (pp) void'(mq.pop_front());
         if (acc) mq.push_back(res);
      end
      #1;
      exp_y = (mq.size() != 0) ? mq[0] : '0;
      chk("in_ready", in_ready, mq.size() < 2);
      chk("out_valid", out_valid, mq.size() != 0);
      chk("y", y, exp_y);
`ifdef LOGIC_FLAGS_EN
      chk("zero", zero, exp_y == '0);
      chk("neg", neg, exp_y[W-1]);
`endif
   endtask

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
   } vec_t;

   vec_t tbl [8];

   initial begin
      logic [W-1:0] ra, rb;
      logic [2:0]   rop;

      tbl[0] = '{3'd0, 16'hF0F0, 16'hFF00, 16'hF000};
      tbl[1] = '{3'd1, 16'hF0F0, 16'hFF00, 16'hFFF0};
      tbl[2] = '{3'd2, 16'hF0F0, 16'hFF00, 16'h0FF0};
      tbl[3] = '{3'd3, 16'hF0F0, 16'hFF00, 16'h0FFF};
      tbl[4] = '{3'd4, 16'hF0F0, 16'hFF00, 16'h000F};
      tbl[5] = '{3'd5, 16'hF0F0, 16'hFF00, 16'hF00F};
      tbl[6] = '{3'd6, 16'hF0F0, 16'hFF00, 16'h0F0F};
      tbl[7] = '{3'd7, 16'hF0F0, 16'hFF00, 16'hF0F0};

      // Reset, with a request present that must be ignored
      cycle(1'b1, 1'b1, 16'h1234, 16'h5678, 3'd1, 1'b1);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_y", y, 16'h0000);

      // Idle cycles with garbage inputs and in_valid=0 change nothing
      cycle(1'b0, 1'b0, 16'hDEAD, 16'hBEEF, 3'd2, 1'b1);
      cycle(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 3'd7, 1'b0);

      // All operations, streaming with out_ready=1
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 1'b1, tbl[i].a, tbl[i].b, tbl[i].op, 1'b1);
         chk($sformatf("op%0d_y", i), y, tbl[i].exp);
      end
      cycle(1'b0, 1'b0, '0, '0, 3'd0, 1'b1);
      chk("drain_empty", out_valid, 1'b0);

      // Backpressure: three requests, only two accepted
      cycle(1'b0, 1'b1, 16'h1111, 16'h0000, 3'd7, 1'b0);
      cycle(1'b0, 1'b1, 16'h2222, 16'h0000, 3'd7, 1'b0);
      chk("bp_full_in_ready", in_ready, 1'b0);
      cycle(1'b0, 1'b1, 16'h3333, 16'h0000, 3'd7, 1'b0);
      chk("bp_hold_y", y, 16'h1111);
      cycle(1'b0, 1'b0, '0, '0, 3'd0, 1'b0);
      chk("bp_hold_y2", y, 16'h1111);
      cycle(1'b0, 1'b0, '0, '0, 3'd0, 1'b1);
      chk("bp_pop1_y", y, 16'h2222);
      chk("bp_pop1_in_ready", in_ready, 1'b1);
      cycle(1'b0, 1'b0, '0, '0, 3'd0, 1'b1);
      chk("bp_pop2_empty", out_valid, 1'b0);

      // Full FIFO ignores a request even when a pop happens that cycle
      cycle(1'b0, 1'b1, 16'hAAAA, 16'h0000, 3'd7, 1'b0);
      cycle(1'b0, 1'b1, 16'hBBBB, 16'h0000, 3'd7, 1'b0);
      cycle(1'b0, 1'b1, 16'hCCCC, 16'h0000, 3'd7, 1'b1);
      chk("full_pop_y", y, 16'hBBBB);
      chk("full_pop_in_ready", in_ready, 1'b1);
      cycle(1'b0, 1'b0, '0, '0, 3'd0, 1'b1);
      chk("full_no_ghost", out_valid, 1'b0);

      // Reset with two results in flight, concurrent accept and pop
      cycle(1'b0, 1'b1, 16'h5A5A, 16'h0000, 3'd7, 1'b0);
      cycle(1'b0, 1'b1, 16'hA5A5, 16'h0000, 3'd7, 1'b0);
      cycle(1'b1, 1'b1, 16'h7777, 16'h0000, 3'd7, 1'b1);
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_y", y, 16'h0000);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, '0, 3'd0, 1'b1);
      chk("mid_rst_no_old", out_valid, 1'b0);

      // Flag corner cases
      cycle(1'b0, 1'b1, 16'h00FF, 16'hFF00, 3'd0, 1'b1);
      chk("flag_and_y", y, 16'h0000);
`ifdef LOGIC_FLAGS_EN
      chk("flag_and_zero", zero, 1'b1);
      chk("flag_and_neg", neg, 1'b0);
`endif
      cycle(1'b0, 1'b1, 16'h0000, 16'h1234, 3'd6, 1'b1);
      chk("flag_not_y", y, 16'hFFFF);
`ifdef LOGIC_FLAGS_EN
      chk("flag_not_zero", zero, 1'b0);
      chk("flag_not_neg", neg, 1'b1);
`endif

      // Continuous streaming at count=1: one result per cycle
      for (int i = 0; i < 100; i++) begin
         ra = W'($urandom); rb = W'($urandom); rop = 3'($urandom_range(0, 7));
         cycle(1'b0, 1'b1, ra, rb, rop, 1'b1);
         chk("stream_y", y, ref_op(rop, ra, rb));
      end

      // Random mix of valid/ready
      for (int i = 0; i < 300; i++) begin
         ra = W'($urandom); rb = W'($urandom); rop = 3'($urandom_range(0, 7));
         cycle(1'b0, 1'($urandom_range(0, 1)), ra, rb, rop, 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/bitwise_pipe.md
BITWISE_PIPE -- requirements
Module: bitwise_pipe

Interface
REQ-001 WIDTH, 16, operand/result width in bits; legal range 1..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 in_valid  input  1  request present on a, b, op.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 op  input  3  operation select, see REQ-014.
REQ-009 out_valid  output  1  result present on y.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 y  output  WIDTH  result.
REQ-012 zero  output  1  flag, present only with LOGIC_FLAGS_EN: y is all zeros.
REQ-013 neg  output  1  flag, present only with LOGIC_FLAGS_EN: y[WIDTH-1].

Function
REQ-014 op encoding shall be: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT a, 111 pass a; per-bit, no carries, b ignored for 110/111.
REQ-015 Accept shall occur when in_valid && in_ready at a rising edge; the result is computed from a, b, op sampled that cycle.
REQ-016 Pop shall occur when out_valid && out_ready at a rising edge.
REQ-017 Results shall be held in a 2-entry FIFO; the head entry drives y and out_valid.
REQ-018 Latency: a result accepted at edge N into an empty FIFO shall show out_valid=1 and the correct y after edge N; no combinational path from a/b/op to y.
REQ-019 in_ready shall be registered and shall equal (count < 2); no combinational path from out_ready to in_ready.
REQ-020 Count transitions: accept only +1; pop only -1; accept and pop together, count unchanged; FIFO order preserved.
REQ-021 With count=2, in_valid shall be ignored (no accept) even if out_ready=1 that cycle; in_ready rises the cycle after the pop.
REQ-022 With count=0, out_valid shall be 0 and y shall be all zeros.
REQ-023 y shall stay stable while out_valid=1 and out_ready=0.
REQ-024 Invalid requests (in_valid=0) shall not change state, whatever a, b, op hold.
REQ-025 Read/write pointers shall be 1 bit and wrap 1->0.

Reset
REQ-026 With rst=1 at an edge: count=0, pointers=0, out_valid=0, y=0, in_ready=1 (zero=1, neg=0 with flags) after that edge.
REQ-027 rst shall override a simultaneous accept or pop; in-flight results shall be discarded.
REQ-028 FIFO data storage need not be cleared; only control state and the output register are reset.

Configuration
REQ-029 Macro LOGIC_FLAGS_EN: defined -> zero and neg ports exist; they are registered with each result and follow the head entry (zero=1, neg=0 when empty); undefined -> ports and flag storage are absent; y/handshake behaviour is identical.

Verification
REQ-030 Reset: rst=1 one cycle -> in_ready=1, out_valid=0, y=0x0000.
REQ-031 All ops, WIDTH=16, a=0xF0F0, b=0xFF00, out_ready=1 -> y = 0xF000, 0xFFF0, 0x0FF0, 0x0FFF, 0x000F, 0xF00F, 0x0F0F, 0xF0F0, each one cycle after accept.
REQ-032 Backpressure: out_ready=0, three valid requests -> two accepted, in_ready=0 after the second; y holds the first result; raise out_ready -> results in order, in_ready=1 one cycle after the first pop.
REQ-033 Simultaneous accept and pop at count=1, continuous streaming -> one result per cycle, count stays 1, no loss or duplication over 100 random ops checked against a model.
REQ-034 Mid-operation reset with count=2 -> out_valid=0 next cycle; the old results never appear.
REQ-035 With LOGIC_FLAGS_EN, AND a=0x00FF b=0xFF00 -> y=0x0000, zero=1, neg=0; NOT a=0x0000 -> y=0xFFFF, zero=0, neg=1.
